// File: rtl/lru_refill_ctrl_if.sv
// Lookup, refill-memory and LRU-update signals of the refill controller.
// Handshakes: o_mem_req is a request that stays asserted with a stable
// o_mem_addr_7 until the memory answers with a one-cycle i_mem_ack; after
// that, each cycle with i_mem_beat_valid=1 is one accepted fill beat (no
// back-pressure). Upstream may present a lookup only while o_busy=0;
// lookups seen while o_busy=1 are dropped.
interface lru_refill_ctrl_if;
  logic       i_lookup_valid;
  logic       i_hit_sig;
  logic [7:0] i_hit_way_8;
  logic [6:0] i_addr_7;
  logic [7:0] i_lru_flag_8;
  logic       o_busy;
  logic       o_mem_req;
  logic [6:0] o_mem_addr_7;
  logic       i_mem_ack;
  logic       i_mem_beat_valid;
  logic [7:0] o_fill_way_8;
  logic       o_fill_done;
  logic       o_upd_valid;
  logic [7:0] o_upd_way_8;
  logic [6:0] o_upd_addr_7;

  // Controller side
  modport slave (
    input  i_lookup_valid, i_hit_sig, i_hit_way_8, i_addr_7, i_lru_flag_8,
    input  i_mem_ack, i_mem_beat_valid,
    output o_busy, o_mem_req, o_mem_addr_7, o_fill_way_8, o_fill_done,
    output o_upd_valid, o_upd_way_8, o_upd_addr_7
  );

  // Upstream cache / memory side
  modport master (
    output i_lookup_valid, i_hit_sig, i_hit_way_8, i_addr_7, i_lru_flag_8,
    output i_mem_ack, i_mem_beat_valid,
    input  o_busy, o_mem_req, o_mem_addr_7, o_fill_way_8, o_fill_done,
    input  o_upd_valid, o_upd_way_8, o_upd_addr_7
  );
endinterface

// File: rtl/lru_refill_ctrl.sv
// Cache refill controller: forwards hits to the LRU buffer as an update,
// and on a miss picks a victim way, requests the line from memory, counts
// BEATS fill beats and then reports the refill done plus an LRU update.
module lru_refill_ctrl #(
  parameter int BEATS = 4
) (
  input  logic               clk,
  input  logic               rst,
  lru_refill_ctrl_if.slave   bus,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [4:0] BEATS_C = 5'(BEATS);

  state_t     state_q, state_d;
  logic [4:0] beat_cnt_q;
  logic [6:0] set_q;
  logic [7:0] victim_q;
  logic       hit_q;
  logic [7:0] hit_way_q;
  logic [6:0] hit_addr_q;

  logic       lookup_acc;
  logic       hit_acc;
  logic       miss_acc;
  logic [7:0] lowest_flag;
  logic [7:0] victim_c;
  logic       beat_last;

  logic       busy_c;
  logic       mem_req_c;
  logic [6:0] mem_addr_c;
  logic [7:0] fill_way_c;
  logic       fill_done_c;
  logic       upd_valid_c;
  logic [7:0] upd_way_c;
  logic [6:0] upd_addr_c;

  // Lookups are only taken in IDLE; everything else counts as busy.
  assign lookup_acc = (state_q == IDLE) && bus.i_lookup_valid;
  assign hit_acc    = lookup_acc && bus.i_hit_sig;
  assign miss_acc   = lookup_acc && !bus.i_hit_sig;

  // Isolating the lowest set bit covers both one-hot and multi-hot flags;
  // an empty flag falls back to way 0.
  assign lowest_flag = bus.i_lru_flag_8 & (~bus.i_lru_flag_8 + 8'd1);
  assign victim_c    = (bus.i_lru_flag_8 == 8'h00) ? 8'h01 : lowest_flag;

  assign beat_last = ((beat_cnt_q + 5'd1) == BEATS_C);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and output decode; hit updates come from the registered pulse.
  always_comb begin
    state_d     = state_q;
    busy_c      = 1'b1;
    mem_req_c   = 1'b0;
    mem_addr_c  = 7'd0;
    fill_way_c  = victim_q;
    fill_done_c = 1'b0;
    upd_valid_c = hit_q;
    upd_way_c   = hit_way_q;
    upd_addr_c  = hit_addr_q;
    case (state_q)
      IDLE: begin
        busy_c     = 1'b0;
        fill_way_c = 8'h00;
        if (miss_acc) state_d = REQ;
      end
      REQ: begin
        mem_req_c  = 1'b1;
        mem_addr_c = set_q;
        if (bus.i_mem_ack) state_d = FILL;
      end
      FILL: begin
        if (bus.i_mem_beat_valid && beat_last) state_d = DONE;
      end
      DONE: begin
        fill_done_c = 1'b1;
        upd_valid_c = 1'b1;
        upd_way_c   = victim_q;
        upd_addr_c  = set_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Miss context, beat counter and the one-cycle-delayed hit update.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= 5'd0;
      set_q      <= 7'd0;
      victim_q   <= 8'h00;
      hit_q      <= 1'b0;
      hit_way_q  <= 8'h00;
      hit_addr_q <= 7'd0;
    end else begin
      hit_q      <= hit_acc;
      hit_way_q  <= hit_acc ? bus.i_hit_way_8 : 8'h00;
      hit_addr_q <= hit_acc ? bus.i_addr_7 : 7'd0;
      if (miss_acc) begin
        set_q    <= bus.i_addr_7;
        victim_q <= victim_c;
      end
      if (state_q == REQ && bus.i_mem_ack)
        beat_cnt_q <= 5'd0;
      else if (state_q == FILL && bus.i_mem_beat_valid)
        beat_cnt_q <= beat_cnt_q + 5'd1;
      else if (state_q == DONE)
        beat_cnt_q <= 5'd0;
    end
  end

  assign bus.o_busy       = busy_c;
  assign bus.o_mem_req    = mem_req_c;
  assign bus.o_mem_addr_7 = mem_addr_c;
  assign bus.o_fill_way_8 = fill_way_c;
  assign bus.o_fill_done  = fill_done_c;
  assign bus.o_upd_valid  = upd_valid_c;
  assign bus.o_upd_way_8  = upd_way_c;
  assign bus.o_upd_addr_7 = upd_addr_c;
  assign dbg_state        = state_q;

endmodule

// File: doc/lru_refill_ctrl.md
LRU_REFILL_CTRL -- requirements
Module: lru_refill_ctrl

Interface
REQ-001 Parameter BEATS, default 4, SHALL set the number of memory fill beats per refill; legal range 1..16.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 i_lookup_valid  input  1  SHALL mark a cache lookup in this cycle.
REQ-005 i_hit_sig  input  1  SHALL indicate a tag hit for the current lookup.
REQ-006 i_hit_way_8  input  8  SHALL carry the one-hot hit way.
REQ-007 i_addr_7  input  7  SHALL carry the set index of the lookup.
REQ-008 i_lru_flag_8  input  8  SHALL carry the victim-way flag from the LRU buffer for the current set.
REQ-009 o_busy  output  1  SHALL tell upstream that lookups are not accepted.
REQ-010 o_mem_req  output  1; o_mem_addr_7  output  7; i_mem_ack  input  1  SHALL form the refill request handshake.
REQ-011 i_mem_beat_valid  input  1  SHALL mark one fill data beat.
REQ-012 o_fill_way_8  output  8  SHALL carry the one-hot way being refilled.
REQ-013 o_fill_done  output  1  SHALL pulse when a refill completes.
REQ-014 o_upd_valid  output  1; o_upd_way_8  output  8; o_upd_addr_7  output  7  SHALL drive the LRU buffer update port (i_hit_sig, i_hit_way_8, i_addr_7).

Function
REQ-015 The FSM SHALL have states IDLE, REQ, FILL, DONE.
REQ-016 In IDLE, a lookup with i_hit_sig=1 SHALL produce, one cycle later, o_upd_valid=1 for one cycle with o_upd_way_8=i_hit_way_8 and o_upd_addr_7=i_addr_7; the state SHALL stay IDLE.
REQ-017 In IDLE, a lookup with i_hit_sig=0 SHALL latch i_addr_7 and the victim way, then move to REQ.
REQ-018 Victim way: i_lru_flag_8 used if one-hot; if multi-hot, the lowest set bit SHALL be used; if zero, way 0 (8'h01).
REQ-019 o_busy SHALL be 0 in IDLE and 1 in REQ, FILL and DONE; lookups while o_busy=1 SHALL be ignored.
REQ-020 In REQ, o_mem_req SHALL be 1 and o_mem_addr_7 SHALL hold the latched set, both stable until i_mem_ack=1; the ack cycle SHALL move to FILL with the beat counter at 0.
REQ-021 The i_mem_ack and i_mem_beat_valid inputs SHALL be ignored in every state other than REQ and FILL respectively.
REQ-022 In FILL, each i_mem_beat_valid SHALL increment the beat counter; the beat that makes count equal BEATS SHALL move to DONE. Cycles without a beat SHALL hold the state.
REQ-023 o_fill_way_8 SHALL equal the latched victim in REQ, FILL and DONE, and 0 in IDLE.
REQ-024 DONE SHALL last exactly one cycle, asserting o_fill_done=1 and o_upd_valid=1 with the latched victim and set; the next state SHALL be IDLE.
REQ-025 A lookup arriving in the first IDLE cycle after DONE SHALL be accepted normally.
REQ-026 Minimum miss latency, from lookup to o_fill_done, SHALL be 2+BEATS cycles when ack and beats are immediate.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, beat counter 0, and all outputs 0 (o_busy, o_mem_req, o_fill_done, o_upd_valid, every addr/way bus) from the next cycle.
REQ-028 rst asserted during REQ or FILL SHALL abort the refill with no o_fill_done and no o_upd_valid; late ack or beats SHALL be ignored.

Verification
REQ-029 Hit: lookup, hit=1, way=8'h20, addr=13 -> next cycle o_upd_valid=1, way 8'h20, addr 13; o_busy stays 0.
REQ-030 Miss: lookup, hit=0, addr=12, lru_flag=8'h04; ack after 3 cycles; 4 beats back-to-back -> o_mem_req held 3 cycles with addr 12; o_fill_done and o_upd_valid pulse once with way 8'h04, addr 12.
REQ-031 Gapped beats: BEATS=4, beats on alternate cycles -> DONE only after the 4th beat; o_busy=1 throughout.
REQ-032 Degenerate flags: lru_flag=8'h00 -> victim 8'h01; lru_flag=8'h90 -> victim 8'h10.
REQ-033 Lookups during busy (hit and miss, addr 5) -> no o_upd_valid and no second request.
REQ-034 rst pulse in FILL after 2 beats -> IDLE next cycle, all outputs 0, extra beats ignored, a new miss then completes normally.
